adc_sample_filter: RTL and testbench
====================================

# adc_sample_filter

Moving-average filter between the ADC capture stage and the diagonal-distance lookup. Accepts raw signed 16-bit IR-sensor samples on a valid strobe, keeps the last 2^LOG2_DEPTH samples in a ring buffer with a running sum, and presents a smoothed signed 16-bit value for the lookup's `adc_data_diag` input. It also flags a stale sensor when samples stop arriving.

## Interface
- `LOG2_DEPTH`, default 3: window depth is 2^LOG2_DEPTH samples (8). Legal range is 1..6.
- `STALE_CYCLES`, default 2_000_000: idle clock cycles without a sample before `stale` asserts (20 ms at 100 MHz).

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `sample_in` in 16, signed: raw ADC conversion result.
- `sample_valid` in 1: one-cycle strobe; `sample_in` is accepted on every cycle it is high, including back-to-back cycles.
- `clear` in 1: synchronous restart of the window without a full reset.
- `adc_data_avg` out 16, signed: filtered sample, feeds `adc_data_diag`.
- `avg_valid` out 1: one-cycle pulse when `adc_data_avg` updates.
- `primed` out 1: window has been fully filled since the last reset or clear.
- `stale` out 1: no sample received for `STALE_CYCLES` cycles.

## Operation
- **State**: ring buffer `buf[0..DEPTH-1]`, write pointer `wr_ptr`, fill count `fill` (0..DEPTH, saturating), running sum `sum` (signed, 16+LOG2_DEPTH bits, never overflows).
- **Accepting a sample** (`sample_valid`=1, `clear`=0):
  - Read `old = buf[wr_ptr]` before writing.
  - Write `buf[wr_ptr] <= sample_in`.
  - Update `sum <= sum + sample_in - (fill==DEPTH ? old : 0)`.
  - Advance `wr_ptr` by 1, wrapping naturally from DEPTH-1 to 0.
  - Increment `fill` if it is below DEPTH.
- **Output selection**:
  - While `fill`<DEPTH after the update, `adc_data_avg` = the latest raw sample (passthrough).
  - Once `fill`==DEPTH, `adc_data_avg` = `sum >>> LOG2_DEPTH`. This is an arithmetic shift, so it floors toward −inf; truncate to 16 bits, which is always in range.
- `primed` rises on the same cycle that the first full-window average is presented, and stays high until reset or clear.
- **clear**:
  - Sets `fill`, `sum` and `wr_ptr` to 0 and `primed` to 0.
  - Buffer contents are left as they are; they are never read while `fill`<DEPTH.
  - `adc_data_avg` holds its last value and `stale` is unaffected.
  - If `clear` and `sample_valid` are high together, the clear is applied and then that sample is taken as sample 1 of the new window. Result: `fill`=1, `sum`=sample, passthrough output.
- **Stale counter**:
  - Saturating idle counter, reset to 0 on every accepted sample.
  - `stale` is 1 while the counter equals `STALE_CYCLES`.
  - After reset the counter starts at 0, so `stale` asserts if no sample arrives within `STALE_CYCLES` cycles.

## Timing
- **Reset values**: `adc_data_avg`=0, `avg_valid`=0, `primed`=0, `stale`=0, `fill`=0, `sum`=0, `wr_ptr`=0, idle counter 0.
- **Pipeline**: two stages.
  - Cycle N: sample accepted.
  - N+1: `sum`, `fill` and the buffer are registered.
  - N+2: `adc_data_avg` updates and `avg_valid` pulses for one cycle. `primed` rises at N+2 of the DEPTH-th sample.
- **Throughput**: one sample per cycle. Back-to-back strobes give back-to-back `avg_valid` pulses with no drops.
- **Clear in flight**: a `clear` at N+1 after a sample at N does not cancel that sample's N+2 output. The output at N+2 is the passthrough or average computed before the clear.
- **Stale**:
  - `stale` rises on the cycle the idle counter reaches `STALE_CYCLES`, i.e. the `STALE_CYCLES`-th idle cycle after the last strobe.
  - It falls the cycle after the next accepted sample.
- **Reset mid-operation**: takes effect at the next edge. Any in-flight `avg_valid` is suppressed.

## Structure
- **Shared package `adc_pkg`**:
  - `ADC_W`=16.
  - `typedef logic signed [ADC_W-1:0] adc_sample_t`.
  - Default `STALE_CYCLES` constant.
  - The lookup stage uses the same sample type.
- **Sub-module `adc_ring_buf`**: the parameterised DEPTH x 16 register buffer.
  - Write port with pointer.
  - Combinational read of the slot being overwritten.
  - The filter holds the sum, fill, output and stale logic.

## Test plan
All scenarios use `LOG2_DEPTH`=3 and `STALE_CYCLES`=100.
1. **Fill then prime**: 8 strobes of 1000, spaced by 3 cycles → samples 1–7 output 1000 with `primed`=0; at the 8th sample's N+2, `adc_data_avg`=1000 and `primed`=1 on the same cycle as `avg_valid`.
2. **Wrap-around**: 8×1000 followed by 4×2000 → last output is 1500; after 4 more ×2000 the output is 2000.
3. **Negative flooring**: 7×0 then −1 → full-window output is −1 (not 0). Then 8×−32768 → output is −32768 with no overflow.
4. **Back-to-back**: 12 strobes on consecutive cycles with values 1..12 → 12 consecutive `avg_valid` pulses. Last output is floor((5+…+12)/8)=8.
5. **Clear and sample together**: with the window primed at 1000, assert `clear` with `sample_valid` and `sample_in`=500 → `primed` is 0 and the output is 500 at N+2. Seven more ×500 → `primed` is 1 and the output is 500.
6. **Stale and reset**:
   - No strobes for 100 cycles after reset → `stale`=1.
   - One strobe → `stale`=0 the next cycle.
   - `reset` asserted mid-fill → all outputs are at their reset values one cycle later.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared ADC sample definitions for the capture, filter and diagonal-distance lookup stages.
package adc_pkg;

  localparam int unsigned ADC_W = 16;

  typedef logic signed [ADC_W-1:0] adc_sample_t;

  // 20 ms at 100 MHz.
  localparam int unsigned STALE_CYCLES_DEFAULT = 2_000_000;

endpackage

// File: rtl/adc_ring_buf.sv
// DEPTH x ADC_W sample window storage; the read port returns the slot about to be overwritten.
module adc_ring_buf
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [LOG2_DEPTH-1:0]   wr_ptr,
  input  logic signed [ADC_W-1:0] wr_data,
  output logic signed [ADC_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

  // No reset: slots are only read once the window is completely refilled.
  adc_sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/adc_sample_filter.sv
// Moving-average filter over the last 2^LOG2_DEPTH ADC samples with a stale-sensor flag.
module adc_sample_filter
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_DEPTH   = 3,
  parameter int unsigned STALE_CYCLES = STALE_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ADC_W-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    clear,
  output logic signed [ADC_W-1:0] adc_data_avg,
  output logic                    avg_valid,
  output logic                    primed,
  output logic                    stale
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = ADC_W + LOG2_DEPTH;
  localparam int unsigned CNT_W = (STALE_CYCLES > 0) ? $clog2(STALE_CYCLES + 1) : 1;
  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);

  if (LOG2_DEPTH < 1 || LOG2_DEPTH > 6) begin : gen_bad_depth
    $error("adc_sample_filter: LOG2_DEPTH must be in 1..6");
  end

  // Stage 1: window state.
  logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d, wr_addr;
  logic [LOG2_DEPTH:0]     fill_q, fill_d, fill_base;
  logic signed [SUM_W-1:0] sum_q, sum_d, sum_base, in_ext, old_ext;
  adc_sample_t             old_sample, last_q;
  logic                    s1_valid_q;
  logic                    full_before;

  // Stage 2: presented output.
  adc_sample_t             avg_q, avg_d;
  logic                    avg_valid_q;
  logic                    primed_q, primed_d;
  logic                    full_q;

  logic [CNT_W-1:0]        idle_q, idle_d;

  adc_ring_buf #(
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ring_buf (
    .clk    (clk),
    .wr_en  (sample_valid),
    .wr_ptr (wr_addr),
    .wr_data(sample_in),
    .rd_data(old_sample)
  );

  // A clear collapses the window first, so a coincident sample lands as sample 1.
  always_comb begin
    wr_addr     = clear ? '0 : wr_ptr_q;
    fill_base   = clear ? '0 : fill_q;
    sum_base    = clear ? '0 : sum_q;
    full_before = (fill_base == FULL);
    in_ext      = {{LOG2_DEPTH{sample_in[ADC_W-1]}}, sample_in};
    old_ext     = {{LOG2_DEPTH{old_sample[ADC_W-1]}}, old_sample};

    sum_d    = sum_base;
    fill_d   = fill_base;
    wr_ptr_d = wr_addr;
    if (sample_valid) begin
      sum_d    = sum_base + in_ext - (full_before ? old_ext : '0);
      fill_d   = full_before ? fill_base : fill_base + 1'b1;
      wr_ptr_d = wr_addr + 1'b1;
    end
  end

  assign full_q = (fill_q == FULL);

  // Uses the pre-edge stage-1 state, so a clear one cycle later cannot cancel this result.
  always_comb begin
    avg_d = avg_q;
    if (s1_valid_q) begin
      avg_d = full_q ? ADC_W'(sum_q >>> LOG2_DEPTH) : last_q;
    end

    primed_d = primed_q;
    if (clear) begin
      primed_d = 1'b0;
    end else if (s1_valid_q && full_q) begin
      primed_d = 1'b1;
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (sample_valid) begin
      idle_d = '0;
    end else if (idle_q != STALE_MAX) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      last_q      <= '0;
      s1_valid_q  <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      idle_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      s1_valid_q  <= sample_valid;
      avg_q       <= avg_d;
      avg_valid_q <= s1_valid_q;
      primed_q    <= primed_d;
      idle_q      <= idle_d;
      if (sample_valid) begin
        last_q <= sample_in;
      end
    end
  end

  assign adc_data_avg = avg_q;
  assign avg_valid    = avg_valid_q;
  assign primed       = primed_q;
  assign stale        = (idle_q == STALE_MAX);

endmodule

// File: tb/tb_adc_sample_filter.sv
// Directed bench for adc_sample_filter with LOG2_DEPTH=3 and STALE_CYCLES=100.
module tb_adc_sample_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               clear;
  logic signed [15:0] adc_data_avg;
  logic               avg_valid;
  logic               primed;
  logic               stale;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adc_sample_filter #(
    .LOG2_DEPTH  (3),
    .STALE_CYCLES(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .clear       (clear),
    .adc_data_avg(adc_data_avg),
    .avg_valid   (avg_valid),
    .primed      (primed),
    .stale       (stale)
  );

  typedef struct {
    logic signed [15:0] smp;
    logic               clr;
    logic signed [15:0] exp_avg;
    logic               exp_primed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic signed [15:0] s, input logic c,
                              input logic signed [15:0] e, input logic p);
    vec_t v;
    v.smp = s;
    v.clr = c;
    v.exp_avg = e;
    v.exp_primed = p;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int b2b_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7, 8};
  int pulses;

  initial begin
    // Fill then prime.
    for (int i = 0; i < 7; i++) add(16'sd1000, 1'b0, 16'sd1000, 1'b0);
    add(16'sd1000, 1'b0, 16'sd1000, 1'b1);
    // Wrap-around: 2000s displace the 1000s one at a time.
    add(16'sd2000, 1'b0, 16'sd1125, 1'b1);
    add(16'sd2000, 1'b0, 16'sd1250, 1'b1);
    add(16'sd2000, 1'b0, 16'sd1375, 1'b1);
    add(16'sd2000, 1'b0, 16'sd1500, 1'b1);
    add(16'sd2000, 1'b0, 16'sd1625, 1'b1);
    add(16'sd2000, 1'b0, 16'sd1750, 1'b1);
    add(16'sd2000, 1'b0, 16'sd1875, 1'b1);
    add(16'sd2000, 1'b0, 16'sd2000, 1'b1);
    // Negative flooring, window restarted by clear on the first zero.
    add(16'sd0, 1'b1, 16'sd0, 1'b0);
    for (int i = 0; i < 6; i++) add(16'sd0, 1'b0, 16'sd0, 1'b0);
    add(-16'sd1, 1'b0, -16'sd1, 1'b1);
    for (int k = 1; k <= 8; k++)
      add(-16'sd32768, 1'b0, (k < 8) ? 16'(-4096 * k - 1) : -16'sd32768, 1'b1);
    // Clear together with a sample.
    add(16'sd1000, 1'b1, 16'sd1000, 1'b0);
    for (int i = 0; i < 6; i++) add(16'sd1000, 1'b0, 16'sd1000, 1'b0);
    add(16'sd1000, 1'b0, 16'sd1000, 1'b1);
    add(16'sd500, 1'b1, 16'sd500, 1'b0);
    for (int i = 0; i < 6; i++) add(16'sd500, 1'b0, 16'sd500, 1'b0);
    add(16'sd500, 1'b0, 16'sd500, 1'b1);

    reset = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_avg", adc_data_avg, 0);
    check("reset_valid", avg_valid, 0);
    check("reset_primed", primed, 0);
    check("reset_stale", stale, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = vecs[i].smp;
      clear = vecs[i].clr;
      @(negedge clk);
      sample_valid = 1'b0;
      clear = 1'b0;
      check($sformatf("vec%0d_early_valid", i), avg_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), avg_valid, 1);
      check($sformatf("vec%0d_avg", i), adc_data_avg, vecs[i].exp_avg);
      check($sformatf("vec%0d_primed", i), primed, vecs[i].exp_primed);
    end

    // Clear alone: output holds, primed drops.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_primed", primed, 0);
    check("clear_hold_avg", adc_data_avg, 500);
    check("clear_no_valid", avg_valid, 0);

    // Back-to-back strobes 1..12.
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 13) begin
        check($sformatf("b2b%0d_valid", c), avg_valid, 1);
        check($sformatf("b2b%0d_avg", c), adc_data_avg, b2b_exp[c-2]);
      end else begin
        check($sformatf("b2b%0d_idle", c), avg_valid, 0);
      end
      if (c == 8) check("b2b_primed_low", primed, 0);
      if (c == 9) check("b2b_primed_high", primed, 1);
      if (avg_valid) pulses++;
      sample_valid = (c < 12);
      sample_in = 16'(c + 1);
    end
    check("b2b_pulse_count", pulses, 12);

    // Clear one cycle after a sample does not cancel that sample's result.
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in = 16'sd100;
    @(negedge clk);
    sample_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("inflight_clear_valid", avg_valid, 1);
    check("inflight_clear_avg", adc_data_avg, 20);

    // Stale after 100 idle cycles from reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (99) @(negedge clk);
    check("stale_at_99", stale, 0);
    @(negedge clk);
    check("stale_at_100", stale, 1);
    sample_valid = 1'b1;
    sample_in = 16'sd7;
    @(negedge clk);
    sample_valid = 1'b0;
    check("stale_cleared", stale, 0);

    // Reset with that sample still in flight.
    reset = 1'b1;
    @(negedge clk);
    check("midreset_valid", avg_valid, 0);
    check("midreset_avg", adc_data_avg, 0);
    check("midreset_primed", primed, 0);
    check("midreset_stale", stale, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
